mem_access_unit: RTL

// - Load/store front end sitting directly upstream of the word-wide data memory (synchronous read, one write port).
// - Accepts byte/halfword/word load and store requests from the CPU on a byte address and sequences the memory.
// - Aligns and sign/zero-extends load data.
// - Performs sub-word stores as read-modify-write on the 32-bit word.

---
 rtl/mem_access_unit.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front end for a word-wide synchronous data memory.
// Handles byte/half/word loads with extension and sub-word stores by read-modify-write.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses trap with rsp_err
// instead of being silently aligned down.
// Ports:
//   clk, reset (async, active-low)
//   req_*  : CPU request (valid/ready, we, size, unsigned, byte addr, wdata)
//   rsp_*  : one-cycle completion pulse with load data and error flag
//   dm_*   : data memory word address, write data, write enable, read data
module mem_access_unit #(
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W+1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] dm_address,
   output logic [31:0]       dm_write_data,
   output logic              dm_we2,
   input  logic [31:0]       dm_read_data
);

   typedef enum logic [2:0] {
      IDLE,
      READ,
      RD_DATA,
      WRITE,
      RESP
   } state_t;

   state_t state, state_nxt;

   logic [ADDR_W+1:0] addr_q;
   logic [1:0]        size_q;
   logic              we_q;
   logic              unsigned_q;
   // Only the low half of the store data is ever merged; word stores
   // load dm_write_data directly at accept.
   logic [15:0]       wdata_q;

   logic              accept;
   logic              req_half;
   logic              req_word;
   logic              misaligned;
   logic [ADDR_W+1:0] addr_in;

   assign req_ready = (state == IDLE);
   assign accept    = req_valid && req_ready;
   assign req_half  = (req_size == 2'b01);
   assign req_word  = req_size[1];

`ifdef LSU_MISALIGN_TRAP_EN
   assign misaligned = (req_half && req_addr[0]) ||
                       (req_word && (req_addr[1:0] != 2'b00));
   assign addr_in    = req_addr;
`else
   // Without trapping, misaligned accesses are aligned down and proceed.
   assign misaligned = 1'b0;
   always_comb begin
      addr_in = req_addr;
      if (req_word)
         addr_in[1:0] = 2'b00;
      else if (req_half)
         addr_in[0] = 1'b0;
   end
`endif

   // Extract the addressed lane from a memory word and extend it.
   function automatic logic [31:0] load_lane(
      input logic [31:0] w,
      input logic [1:0]  a,
      input logic [1:0]  sz,
      input logic        u
   );
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = w[{a, 3'b000} +: 8];
      h = a[1] ? w[31:16] : w[15:0];
      if (sz[1])
         r = w;
      else if (sz[0])
         r = u ? {16'h0000, h} : {{16{h[15]}}, h};
      else
         r = u ? {24'h000000, b} : {{24{b[7]}}, b};
      return r;
   endfunction

   // Overwrite the addressed byte/half of the old word with new store data.
   function automatic logic [31:0] merge_lane(
      input logic [31:0] w,
      input logic [1:0]  a,
      input logic [1:0]  sz,
      input logic [15:0] d
   );
      logic [31:0] m;
      m = w;
      if (sz == 2'b01) begin
         if (a[1])
            m[31:16] = d;
         else
            m[15:0] = d;
      end else begin
         m[{a, 3'b000} +: 8] = d[7:0];
      end
      return m;
   endfunction

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (accept) begin
               if (misaligned)
                  state_nxt = RESP;
               else if (req_we && req_word)
                  state_nxt = WRITE;
               else
                  state_nxt = READ;
            end
         end
         READ:    state_nxt = RD_DATA;
         RD_DATA: state_nxt = we_q ? WRITE : RESP;
         WRITE:   state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign dm_we2     = (state == WRITE);
   assign rsp_valid  = (state == RESP);
   assign dm_address = addr_q[ADDR_W+1:2];

   // Request capture and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q        <= '0;
         size_q        <= 2'b00;
         we_q          <= 1'b0;
         unsigned_q    <= 1'b0;
         wdata_q       <= 16'h0000;
         dm_write_data <= 32'h0000_0000;
         rsp_rdata     <= 32'h0000_0000;
      end else begin
         if (accept) begin
            addr_q     <= addr_in;
            size_q     <= req_size;
            we_q       <= req_we;
            unsigned_q <= req_unsigned;
            wdata_q    <= req_wdata[15:0];
            if (req_we && req_word && !misaligned)
               dm_write_data <= req_wdata;
         end
         if (state == RD_DATA) begin
            if (we_q)
               dm_write_data <= merge_lane(dm_read_data, addr_q[1:0],
                                           size_q, wdata_q);
            else
               rsp_rdata <= load_lane(dm_read_data, addr_q[1:0],
                                      size_q, unsigned_q);
         end
         if (state == RESP)
            rsp_rdata <= 32'h0000_0000;
      end
   end

`ifdef LSU_MISALIGN_TRAP_EN
   logic err_q;

   // Error flag is set on accept and shown during RESP only.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         err_q <= 1'b0;
      else if (accept)
         err_q <= misaligned;
      else if (state == RESP)
         err_q <= 1'b0;
   end

   assign rsp_err = err_q;
`else
   assign rsp_err = 1'b0;
`endif

endmodule
